// File: rtl/diff_arb_pkg.sv
// -----------------------------------------------------------------------------
// diff_arb_pkg
// Shared definitions for the two-requester subtract arbiter:
//   DIFF_WIDTH  - default operand/result width
//   NUM_REQ     - number of requesters sharing the subtractor
//   arb_state_t - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package diff_arb_pkg;

    localparam int DIFF_WIDTH = 32;
    localparam int NUM_REQ    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/Diff.sv
// -----------------------------------------------------------------------------
// Diff
// Combinational subtractor, out = a - b modulo 2^WIDTH.
// Ports:
//   a   - minuend
//   b   - subtrahend
//   out - wrapped difference
// -----------------------------------------------------------------------------
module Diff #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out
);

    assign out = a - b;

endmodule

// File: rtl/diff_arbiter.sv
// -----------------------------------------------------------------------------
// diff_arbiter
// Two requesters share one subtractor. A round-robin grant picks one operand
// pair in IDLE, the difference and flags are registered in EXEC, and the
// result is held in RESP until the consumer takes it.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   reqN_valid/a/b/ready     - requester N operand handshake (N = 0, 1)
//   rsp_valid/id/diff        - held response, owning requester, a - b
//   rsp_zero/neg/borrow      - diff == 0, diff MSB, a < b (unsigned)
//   rsp_ready                - consumer accepts the response
//
// state | meaning
// IDLE  | arbitrate, assert ready to the granted requester only
// EXEC  | subtract latched operands, register result and flags
// RESP  | hold response until rsp_ready
// -----------------------------------------------------------------------------
module diff_arbiter
    import diff_arb_pkg::*;
#(
    parameter int WIDTH = DIFF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_diff,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_borrow,
    input  logic             rsp_ready
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant;
    logic            grant_vld;
    logic            hs;
    logic [ID_W-1:0] lat_id;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic [WIDTH-1:0] diff_out;

    Diff #(.WIDTH(WIDTH)) u_diff (
        .a   (lat_a),
        .b   (lat_b),
        .out (diff_out)
    );

    // A lone requester wins outright; on a tie the one not served last wins.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign hs = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Readies are gated with rst so nothing is offered while reset is held.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = !rst && grant_vld && (grant == 1'b0);
                req1_ready = !rst && grant_vld && (grant == 1'b1);
                if (grant_vld) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            lat_id     <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_diff   <= '0;
            rsp_zero   <= 1'b0;
            rsp_neg    <= 1'b0;
            rsp_borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        lat_a      <= grant ? req1_a : req0_a;
                        lat_b      <= grant ? req1_b : req0_b;
                        lat_id     <= grant;
                        last_grant <= grant;
                    end
                end
                EXEC: begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= lat_id;
                    rsp_diff   <= diff_out;
                    rsp_zero   <= (diff_out == '0);
                    rsp_neg    <= diff_out[WIDTH-1];
                    rsp_borrow <= (lat_a < lat_b);
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_diff_arbiter.sv
// -----------------------------------------------------------------------------
// tb_diff_arbiter
// Self-checking bench for diff_arbiter: directed operand cases, backpressure,
// mid-response reset, tie arbitration order, then randomized traffic checked
// every cycle against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_diff_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_id;
    logic [W-1:0] rsp_diff;
    logic         rsp_zero;
    logic         rsp_neg;
    logic         rsp_borrow;
    logic         rsp_ready = 1'b1;

    diff_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_diff   (rsp_diff),
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
        .rsp_borrow (rsp_borrow),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic         id;
        logic [W-1:0] diff;
        logic         zero;
        logic         neg;
        logic         borrow;
    } exp_t;

    exp_t   exp_q[$];
    int     obs_q[$];
    int     m_phase = 0;   // 0 free, 1 computing, 2 response on outputs
    logic   m_last  = 1'b1;
    logic   v0, v1, g;
    logic [W-1:0] ma, mb;
    exp_t   e;

    function automatic exp_t expect_of(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        r.id     = id;
        r.diff   = a - b;
        r.zero   = (a == b);
        r.neg    = (r.diff >= 32'h8000_0000);
        r.borrow = (a < b);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_diff", rsp_diff, 0);
            check("rst_rsp_zero", rsp_zero, 0);
            check("rst_rsp_neg", rsp_neg, 0);
            check("rst_rsp_borrow", rsp_borrow, 0);
            check("rst_req0_ready", req0_ready, 0);
            check("rst_req1_ready", req1_ready, 0);
            m_phase = 0;
            m_last  = 1'b1;
            exp_q.delete();
        end else begin
            if (req0_valid && req0_ready) obs_q.push_back(0);
            if (req1_valid && req1_ready) obs_q.push_back(1);
            case (m_phase)
                0: begin
                    v0 = req0_valid;
                    v1 = req1_valid;
                    g  = (v0 && v1) ? !m_last : v1;
                    check("idle_req0_ready", req0_ready, v0 && !g);
                    check("idle_req1_ready", req1_ready, v1 && g);
                    check("idle_rsp_valid", rsp_valid, 0);
                    if (v0 || v1) begin
                        ma = g ? req1_a : req0_a;
                        mb = g ? req1_b : req0_b;
                        exp_q.push_back(expect_of(g, ma, mb));
                        m_last  = g;
                        m_phase = 1;
                    end
                end
                1: begin
                    check("exec_req0_ready", req0_ready, 0);
                    check("exec_req1_ready", req1_ready, 0);
                    check("exec_rsp_valid", rsp_valid, 0);
                    m_phase = 2;
                end
                default: begin
                    check("resp_req0_ready", req0_ready, 0);
                    check("resp_req1_ready", req1_ready, 0);
                    check("resp_rsp_valid", rsp_valid, 1);
                    if (exp_q.size() == 0) begin
                        check("resp_expected", 0, 1);
                    end else begin
                        e = exp_q[0];
                        check("resp_id", rsp_id, e.id);
                        check("resp_diff", rsp_diff, e.diff);
                        check("resp_zero", rsp_zero, e.zero);
                        check("resp_neg", rsp_neg, e.neg);
                        check("resp_borrow", rsp_borrow, e.borrow);
                        if (rsp_ready) begin
                            void'(exp_q.pop_front());
                            m_phase = 0;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
    endtask

    task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic ez, input logic en, input logic eb,
                         input string tag, output int waited);
        @(posedge clk); #1;
        drive_req(id, a, b);
        waited = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
                waited = k;
                break;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (waited < 0) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        @(negedge clk);
        check({tag, "_t1_valid"}, rsp_valid, 0);
        @(negedge clk);
        check({tag, "_t2_valid"}, rsp_valid, 1);
        check({tag, "_id"}, rsp_id, id);
        check({tag, "_diff"}, rsp_diff, ed);
        check({tag, "_zero"}, rsp_zero, ez);
        check({tag, "_neg"}, rsp_neg, en);
        check({tag, "_borrow"}, rsp_borrow, eb);
    endtask

    task automatic wait_ready0(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic backpressure();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_req(0, 5, 2);
        wait_ready0("bp_hs");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive_req(1, 9, 4);
        @(negedge clk);
        @(negedge clk);
        check("bp_first_valid", rsp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_diff", rsp_diff, 3);
            check("bp_hold_id", rsp_id, 0);
            check("bp_hold_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic reset_test();
        bit seen = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_req(0, 3, 1);
        wait_ready0("rt_hs");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("rt_resp_timeout", 0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rt_mid_valid", rsp_valid, 0);
        check("rt_mid_diff", rsp_diff, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rt_no_stale", rsp_valid, 0);
        end
    endtask

    task automatic contention();
        obs_q.delete();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drive_req(0, 20, 5);
        drive_req(1, 5, 20);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (obs_q.size() >= 4) break;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("cont_count_ge4", obs_q.size() >= 4, 1);
        if (obs_q.size() >= 4) begin
            check("cont_grant0", obs_q[0], 0);
            check("cont_grant1", obs_q[1], 1);
            check("cont_grant2", obs_q[2], 0);
            check("cont_grant3", obs_q[3], 1);
        end
    endtask

    // ---------------- random stimulus ----------------
    function automatic logic [W-1:0] rand_val(input int kind);
        case (kind)
            0:       return W'($urandom_range(0, 3));
            1:       return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
            2:       return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic new_op(input bit id);
        logic [W-1:0] a, b;
        a = rand_val($urandom_range(0, 5));
        b = ($urandom_range(0, 3) == 0) ? a : rand_val($urandom_range(0, 5));
        drive_req(id, a, b);
    endtask

    task automatic run_random(input int cycles);
        bit [1:0] pend = 2'b00;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) pend[0] = 1'b0;
            if (req1_valid && req1_ready) pend[1] = 1'b0;
            @(posedge clk); #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < 2; n++) begin
                if (!pend[n]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[n] = 1'b1;
                        new_op(n[0]);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    pend[n] = 1'b0;
                end
            end
            req0_valid = pend[0];
            req1_valid = pend[1];
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    int waited;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        do_op(0, 10, 7, 3, 0, 0, 0, "op_10_7", waited);
        check("first_grant_wait", waited, 0);
        do_op(1, 7, 7, 0, 1, 0, 0, "op_7_7", waited);
        do_op(0, 0, 1, 32'hFFFF_FFFF, 0, 1, 1, "op_wrap", waited);
        backpressure();
        reset_test();
        contention();
        run_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/diff_arbiter.md
DIFF_ARBITER -- requirements
Module: diff_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester n presents an operand pair.
REQ-005 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, WIDTH bits each: minuend (a) and subtrahend (b) for requester n.
REQ-006 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: requester n's operands are accepted this cycle.
REQ-007 The block SHALL have port rsp_valid, output, 1 bit: a response is held on the rsp_* outputs.
REQ-008 The block SHALL have port rsp_id, output, 1 bit: index of the requester the response belongs to.
REQ-009 The block SHALL have port rsp_diff, output, WIDTH bits: a - b.
REQ-010 The block SHALL have port rsp_zero, output, 1 bit: rsp_diff equals 0.
REQ-011 The block SHALL have port rsp_neg, output, 1 bit: rsp_diff[WIDTH-1].
REQ-012 The block SHALL have port rsp_borrow, output, 1 bit: a < b, compared unsigned.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-015 In IDLE the block SHALL assert reqN_ready for the granted requester only; a handshake is reqN_valid & reqN_ready.
REQ-016 With exactly one requester valid in IDLE, that requester SHALL be granted.
REQ-017 With both requesters valid in IDLE, the requester not named by last_grant SHALL be granted (round-robin).
REQ-018 With neither requester valid in IDLE, no ready SHALL be asserted and last_grant SHALL be unchanged.
REQ-019 On a handshake the block SHALL latch a, b and the requester index, update last_grant to that index, and move IDLE->EXEC.
REQ-020 In EXEC the block SHALL compute a - b via the shared subtractor on the latched operands, register the diff and all flags, and move EXEC->RESP.
REQ-021 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs SHALL stay stable until rsp_ready = 1, after which the next state SHALL be IDLE.
REQ-022 Latency SHALL be: handshake at cycle T gives rsp_valid = 1 at cycle T+2.
REQ-023 Maximum throughput SHALL be one operation per 3 cycles when rsp_ready is held at 1.
REQ-024 Both reqN_ready outputs SHALL be 0 in EXEC and RESP; requests arriving then SHALL wait without being dropped or reordered.
REQ-025 Subtraction SHALL wrap modulo 2^WIDTH with no overflow flag, e.g. 0 - 1 gives all ones with rsp_neg = 1 and rsp_borrow = 1.
REQ-026 A requester deasserting valid before its handshake SHALL NOT change last_grant.

Reset
REQ-027 While rst = 1 the block SHALL force: state IDLE, last_grant = 1 (so requester 0 wins the first tie), rsp_valid = 0, rsp_id = 0, rsp_diff = 0, rsp_zero = 0, rsp_neg = 0, rsp_borrow = 0, and both reqN_ready = 0.
REQ-028 Reset asserted in EXEC or RESP SHALL abandon the in-flight operation with no response ever emitted for it.
REQ-029 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-030 Shared package diff_arb_pkg SHALL hold the FSM state enum (IDLE, EXEC, RESP), the default WIDTH constant and the requester count constant (2).
REQ-031 The block SHALL instantiate exactly one existing Diff module as its shared subtractor (ports a, b, out); the FSM, arbiter and response registers SHALL live in diff_arbiter.
REQ-032 The borrow flag SHALL be computed in diff_arbiter by unsigned comparison of the latched operands.

Verification
REQ-033 Reset test: assert rst mid-RESP -> all rsp_* outputs 0 and state IDLE immediately; no stale response after release.
REQ-034 Single-requester test: req0 a=10, b=7 -> rsp_valid at T+2 with rsp_id=0, rsp_diff=3, zero=0, neg=0, borrow=0.
REQ-035 Equal-operands test: req1 a=7, b=7 -> rsp_id=1, rsp_diff=0, rsp_zero=1, rsp_borrow=0.
REQ-036 Wrap test: req0 a=0, b=1 -> rsp_diff=32'hFFFFFFFF, rsp_neg=1, rsp_borrow=1.
REQ-037 Contention test: both requesters held valid for 4 operations -> grant order 0,1,0,1.
REQ-038 Backpressure test: rsp_ready=0 for 5 cycles -> rsp_* stable and both ready outputs 0 throughout; IDLE entered the cycle after rsp_ready=1.
